data_mem_mmio: RTL and testbench

- Data-memory stage directly downstream of the CPU core's load/store port.
- Consumes mem_rd, mem_wr, ram_addr and data_mem_in from the core, and returns data_mem_out for load instructions.
- Contains the word-addressed data RAM and a memory-mapped I/O window at the top of the 12-bit address space.
- The I/O window holds an output port, a free-running cycle counter, and a byte TX FIFO drained through a valid/ready handshake.

---
 rtl/data_mem_mmio.sv | 163 ++++++++++++++++
 tb/tb_data_mem_mmio.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_mmio.sv
// Data-memory stage: word-addressed RAM plus a 16-word MMIO window at the top
// of the address space (GPIO, free-running cycle counter, byte TX FIFO).
// Loads are a combinational decode; stores, pushes and pops happen on the clock edge.
module data_mem_mmio #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned GPIO_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       data_mem_in,
    output logic [31:0]       data_mem_out,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned RAM_DEPTH = (1 << ADDR_W) - 16;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);

    // Offsets within the MMIO window (top 16 words)
    localparam logic [3:0] OFF_GPIO   = 4'h0;
    localparam logic [3:0] OFF_CYCLE  = 4'h1;
    localparam logic [3:0] OFF_TXDATA = 4'h2;
    localparam logic [3:0] OFF_TXSTAT = 4'h3;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [31:0]       r_mem [RAM_DEPTH];
    logic [7:0]        r_fifo [FIFO_DEPTH];
    logic [GPIO_W-1:0] r_gpio;
    logic [31:0]       r_cycle;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_ovf;

    logic              w_is_io;
    logic [3:0]        w_off;
    logic              w_wr_ram;
    logic              w_wr_gpio;
    logic              w_wr_cycle;
    logic              w_wr_txdata;
    logic              w_wr_txstat;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic [7:0]        w_cnt8;
    logic [31:0]       w_status;
    logic [31:0]       w_rd_data;

    assign w_is_io     = &ram_addr[ADDR_W-1:4];
    assign w_off       = ram_addr[3:0];
    assign w_wr_ram    = mem_wr && !w_is_io;
    assign w_wr_gpio   = mem_wr && w_is_io && (w_off == OFF_GPIO);
    assign w_wr_cycle  = mem_wr && w_is_io && (w_off == OFF_CYCLE);
    assign w_wr_txdata = mem_wr && w_is_io && (w_off == OFF_TXDATA);
    assign w_wr_txstat = mem_wr && w_is_io && (w_off == OFF_TXSTAT);

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_push  = w_wr_txdata && (!w_full || w_pop);

    assign w_cnt8   = 8'(r_count);
    assign w_status = {16'h0, w_cnt8, 5'b0, r_ovf, w_empty, w_full};

    assign gpio_out = r_gpio;
    assign tx_data  = r_fifo[r_rd_ptr];
    assign tx_valid = !w_empty;

    // Load path: combinational decode, zero when no load is requested
    always_comb begin
        w_rd_data = 32'h0;
        if (mem_rd) begin
            if (!w_is_io) begin
                w_rd_data = r_mem[ram_addr];
            end else begin
                case (w_off)
                    OFF_GPIO:   w_rd_data = 32'(r_gpio);
                    OFF_CYCLE:  w_rd_data = r_cycle;
                    OFF_TXSTAT: w_rd_data = w_status;
                    default:    w_rd_data = 32'h0;
                endcase
            end
        end
    end

    assign data_mem_out = w_rd_data;

    // RAM array: contents survive reset, but a store during reset is dropped
    always_ff @(posedge clk) begin
        if (!reset && w_wr_ram) begin
            r_mem[ram_addr] <= data_mem_in;
        end
    end

    // FIFO storage: no reset needed, pointers define which entries are live
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_fifo[r_wr_ptr] <= data_mem_in[7:0];
        end
    end

    // GPIO register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gpio <= '0;
        end else if (w_wr_gpio) begin
            r_gpio <= data_mem_in[GPIO_W-1:0];
        end
    end

    // Cycle counter: a store loads it and suppresses that cycle's increment
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= 32'h0;
        end else if (w_wr_cycle) begin
            r_cycle <= data_mem_in;
        end else begin
            r_cycle <= r_cycle + 32'h1;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: set on a dropped push, cleared by any write to TX_STATUS
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_wr_txstat) begin
            r_ovf <= 1'b0;
        end else if (w_wr_txdata && !w_push) begin
            r_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio. Inputs change on the falling edge,
// outputs are sampled 1 time unit later; expected values go through scoreboard queues.
module tb_data_mem_mmio;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd;
    logic        mem_wr;
    logic [11:0] ram_addr;
    logic [31:0] data_mem_in;
    logic [31:0] data_mem_out;
    logic [7:0]  gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] exp_w;
    logic [31:0] got_w;
    logic [7:0]  exp_b;

    always #5 clk = ~clk;

    data_mem_mmio #(
        .ADDR_W    (12),
        .GPIO_W    (8),
        .FIFO_DEPTH(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .ram_addr    (ram_addr),
        .data_mem_in (data_mem_in),
        .data_mem_out(data_mem_out),
        .gpio_out    (gpio_out),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    // One store cycle; returns on the falling edge after the write edge
    task automatic store(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_rd      = 1'b0;
        mem_wr      = 1'b1;
        ram_addr    = a;
        data_mem_in = d;
        @(negedge clk);
        mem_wr = 1'b0;
    endtask

    // Combinational load at the current time
    task automatic load(input logic [11:0] a, output logic [31:0] d);
        mem_rd   = 1'b1;
        ram_addr = a;
        #1;
        d = data_mem_out;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if (gpio_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_gpio got=%h exp=00", gpio_out);
        end
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid);
        end
        exp_q.push_back(32'h0000_0002);
        load(12'hFF3, got_w);
        exp_w = exp_q.pop_front();
        n_tests++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL reset_status got=%h exp=%h", got_w, exp_w);
        end
    endtask

    task automatic test_ram_map;
        exp_q.push_back(32'hDEAD_BEEF);
        store(12'h010, 32'hDEAD_BEEF);
        load(12'h010, got_w);
        exp_w = exp_q.pop_front();
        n_tests++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL ram_rw got=%h exp=%h", got_w, exp_w);
        end
        exp_q.push_back(32'h0);
        mem_rd = 1'b0;
        #1;
        exp_w = exp_q.pop_front();
        n_tests++;
        if (data_mem_out !== exp_w) begin
            n_fail++; $display("FAIL rd_low got=%h exp=%h", data_mem_out, exp_w);
        end
        exp_q.push_back(32'h0);
        load(12'hFF8, got_w);
        exp_w = exp_q.pop_front();
        n_tests++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL reserved_rd got=%h exp=%h", got_w, exp_w);
        end
        exp_q.push_back(32'h0);
        store(12'hFF8, 32'h1234_5678);
        load(12'hFF8, got_w);
        exp_w = exp_q.pop_front();
        n_tests++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL reserved_wr got=%h exp=%h", got_w, exp_w);
        end
        exp_q.push_back(32'h0);
        load(12'hFF2, got_w);
        exp_w = exp_q.pop_front();
        n_tests++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL txdata_rd got=%h exp=%h", got_w, exp_w);
        end
    endtask

    task automatic test_read_during_write;
        store(12'h020, 32'h0000_1111);
        exp_q.push_back(32'h0000_1111);
        exp_q.push_back(32'h0000_2222);
        mem_rd      = 1'b1;
        mem_wr      = 1'b1;
        ram_addr    = 12'h020;
        data_mem_in = 32'h0000_2222;
        #1;
        exp_w = exp_q.pop_front();
        n_tests++;
        if (data_mem_out !== exp_w) begin
            n_fail++; $display("FAIL rdw_old got=%h exp=%h", data_mem_out, exp_w);
        end
        @(negedge clk);
        mem_wr = 1'b0;
        #1;
        exp_w = exp_q.pop_front();
        n_tests++;
        if (data_mem_out !== exp_w) begin
            n_fail++; $display("FAIL rdw_new got=%h exp=%h", data_mem_out, exp_w);
        end
    endtask

    task automatic test_gpio_reset;
        store(12'hFF0, 32'h0000_01A5);
        #1;
        n_tests++;
        if (gpio_out !== 8'hA5) begin
            n_fail++; $display("FAIL gpio_out got=%h exp=a5", gpio_out);
        end
        exp_q.push_back(32'h0000_00A5);
        load(12'hFF0, got_w);
        exp_w = exp_q.pop_front();
        n_tests++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL gpio_rd got=%h exp=%h", got_w, exp_w);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if (gpio_out !== 8'h00) begin
            n_fail++; $display("FAIL gpio_reset got=%h exp=00", gpio_out);
        end
        exp_q.push_back(32'hDEAD_BEEF);
        load(12'h010, got_w);
        exp_w = exp_q.pop_front();
        n_tests++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL ram_keep got=%h exp=%h", got_w, exp_w);
        end
    endtask

    task automatic test_cycle;
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0000);
        store(12'hFF1, 32'hFFFF_FFFE);
        load(12'hFF1, got_w);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
                got_w = data_mem_out;
            end
            exp_w = exp_q.pop_front();
            n_tests++;
            if (got_w !== exp_w) begin
                n_fail++; $display("FAIL cycle_%0d got=%h exp=%h", i, got_w, exp_w);
            end
        end
    endtask

    task automatic test_fifo_overflow;
        tx_ready = 1'b0;
        @(negedge clk);
        mem_rd   = 1'b0;
        mem_wr   = 1'b1;
        ram_addr = 12'hFF2;
        for (int i = 1; i <= 9; i++) begin
            data_mem_in = 32'(i);
            if (i <= 8) tx_q.push_back(8'(i));
            @(negedge clk);
        end
        mem_wr = 1'b0;
        exp_q.push_back(32'h0000_0805);
        load(12'hFF3, got_w);
        exp_w = exp_q.pop_front();
        n_tests++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL ovf_status got=%h exp=%h", got_w, exp_w);
        end
        tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_b = tx_q.pop_front();
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
                n_fail++;
                $display("FAIL drain_%0d got=%b/%h exp=1/%h", k, tx_valid, tx_data, exp_b);
            end
            @(negedge clk);
            #1;
        end
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_valid got=%b exp=0", tx_valid);
        end
        exp_q.push_back(32'h0000_0006);
        exp_w = exp_q.pop_front();
        n_tests++;
        if (data_mem_out !== exp_w) begin
            n_fail++; $display("FAIL drain_status got=%h exp=%h", data_mem_out, exp_w);
        end
        tx_ready = 1'b0;
        exp_q.push_back(32'h0000_0002);
        store(12'hFF3, 32'hFFFF_FFFF);
        load(12'hFF3, got_w);
        exp_w = exp_q.pop_front();
        n_tests++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL ovf_clear got=%h exp=%h", got_w, exp_w);
        end
    endtask

    task automatic test_full_push_pop;
        tx_ready = 1'b0;
        @(negedge clk);
        mem_rd   = 1'b0;
        mem_wr   = 1'b1;
        ram_addr = 12'hFF2;
        for (int i = 0; i < 8; i++) begin
            data_mem_in = 32'h10 + 32'(i);
            tx_q.push_back(8'h10 + 8'(i));
            @(negedge clk);
        end
        // Full: push 0x55 while popping the head in the same cycle
        tx_ready    = 1'b1;
        data_mem_in = 32'h55;
        tx_q.push_back(8'h55);
        #1;
        exp_b = tx_q.pop_front();
        n_tests++;
        if (tx_data !== exp_b) begin
            n_fail++; $display("FAIL fpp_head got=%h exp=%h", tx_data, exp_b);
        end
        @(negedge clk);
        mem_wr   = 1'b0;
        tx_ready = 1'b0;
        exp_q.push_back(32'h0000_0801);
        load(12'hFF3, got_w);
        exp_w = exp_q.pop_front();
        n_tests++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL fpp_status got=%h exp=%h", got_w, exp_w);
        end
        tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_b = tx_q.pop_front();
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
                n_fail++;
                $display("FAIL fpp_pop_%0d got=%b/%h exp=1/%h", k, tx_valid, tx_data, exp_b);
            end
            @(negedge clk);
            #1;
        end
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL fpp_empty got=%b exp=0", tx_valid);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_handshake;
        tx_ready = 1'b0;
        @(negedge clk);
        mem_rd   = 1'b0;
        mem_wr   = 1'b1;
        ram_addr = 12'hFF2;
        for (int i = 0; i < 3; i++) begin
            data_mem_in = 32'hA0 + 32'(i);
            @(negedge clk);
        end
        mem_wr   = 1'b0;
        reset    = 1'b1;
        tx_ready = 1'b1;
        #1;
        n_tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA0) begin
            n_fail++; $display("FAIL rst_pre got=%b/%h exp=1/a0", tx_valid, tx_data);
        end
        @(negedge clk);
        reset    = 1'b0;
        tx_ready = 1'b0;
        #1;
        n_tests++;
        if (tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid got=%b exp=0", tx_valid);
        end
        exp_q.push_back(32'h0000_0002);
        load(12'hFF3, got_w);
        exp_w = exp_q.pop_front();
        n_tests++;
        if (got_w !== exp_w) begin
            n_fail++; $display("FAIL rst_status got=%h exp=%h", got_w, exp_w);
        end
    endtask

    initial begin
        reset       = 1'b1;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        ram_addr    = 12'h0;
        data_mem_in = 32'h0;
        tx_ready    = 1'b0;
        test_reset();
        test_ram_map();
        test_read_during_write();
        test_gpio_reset();
        test_cycle();
        test_fifo_overflow();
        test_full_push_pop();
        test_reset_mid_handshake();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
